// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one pipelined 32x32 low-word multiplier.
// The requester ID travels with each operation through a tag pipeline and selects the response strobe.
module mul_share_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [32*N_REQ-1:0]    req_src1,
    input  logic [32*N_REQ-1:0]    req_src2,
    input  logic                   stall,
    output logic [31:0]            mul_src1,
    output logic [31:0]            mul_src2,
    input  logic [31:0]            mul_result,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [31:0]            rsp_result,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Round-robin state and grant decision
    logic [PTR_W-1:0]  r_ptr;
    logic              w_found;
    logic [PTR_W-1:0]  w_gid;
    int                w_idx;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_hs;
    logic [PTR_W-1:0]  w_ptr_next;

    // Operand selection
    logic [31:0]       w_src1_arr [N_REQ];
    logic [31:0]       w_src2_arr [N_REQ];
    logic [31:0]       w_op1;
    logic [31:0]       w_op2;

    // Issue registers, tag pipeline and response registers
    logic [31:0]                   r_src1;
    logic [31:0]                   r_src2;
    logic [MUL_LATENCY:0]          r_tag_vld;
    logic [MUL_LATENCY:0][PTR_W-1:0] r_tag_id;
    logic [N_REQ-1:0]              w_rsp_dec;
    logic [N_REQ-1:0]              r_rsp_valid;
    logic [31:0]                   r_rsp_result;
    logic                          r_busy;
    logic [CNT_W-1:0]              r_op_count;

    // Search from the pointer, wrapping once; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = PTR_W'(w_idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_gnt[gi]      = w_found && (w_gid == PTR_W'(gi));
            assign w_src1_arr[gi] = req_src1[32*gi +: 32];
            assign w_src2_arr[gi] = req_src2[32*gi +: 32];
            assign w_rsp_dec[gi]  = r_tag_vld[MUL_LATENCY] && (r_tag_id[MUL_LATENCY] == PTR_W'(gi));
        end
    endgenerate

    assign w_hs       = w_found & ~stall & ~reset;
    assign req_ready  = w_hs ? w_gnt : '0;
    assign w_op1      = w_src1_arr[w_gid];
    assign w_op2      = w_src2_arr[w_gid];
    assign w_ptr_next = (w_gid == PTR_W'(N_REQ - 1)) ? '0 : w_gid + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_op_count <= '0;
        end else if (w_hs) begin
            r_ptr      <= w_ptr_next;
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    // Operands only load on a handshake so the multiplier inputs stay quiet when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (w_hs) begin
            r_src1 <= w_op1;
            r_src2 <= w_op2;
        end
    end

    // Tag pipeline never stalls; it lines up with the multiplier's fixed latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_tag_vld[0] <= w_hs;
            r_tag_id[0]  <= w_gid;
            for (int s = 1; s <= MUL_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
            // Next-state OR of all stages plus the response slot, so busy covers the strobe cycle.
            r_busy <= w_hs | (|r_tag_vld);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
        end else begin
            r_rsp_valid <= w_rsp_dec;
            if (r_tag_vld[MUL_LATENCY]) begin
                r_rsp_result <= mul_result;
            end
        end
    end

    assign mul_src1   = r_src1;
    assign mul_src2   = r_src2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a one-cycle multiplier model and a response scoreboard.
module tb_mul_share_arbiter;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_src1;
    logic [32*N-1:0]   req_src2;
    logic              stall;
    logic [31:0]       mul_src1;
    logic [31:0]       mul_src2;
    logic [31:0]       mul_result;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_result;
    logic              busy;
    logic [31:0]       op_count;

    always #5 clk = ~clk;

    // Multiplier cell: one register stage, low 32 bits of the product.
    always @(posedge clk) mul_result <= mul_src1 * mul_src2;

    mul_share_arbiter #(.N_REQ(N), .MUL_LATENCY(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .stall(stall),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy), .op_count(op_count)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    logic [31:0] m_cnt = 0;
    int          rem[N];
    logic [31:0] s1[N];
    logic [31:0] s2[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (rem[i] > 0);
            req_src1[32*i +: 32]  = s1[i];
            req_src2[32*i +: 32]  = s2[i];
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance.
    task automatic tick();
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        logic [31:0]  prod;
        exp_t         e;
        int           g;
        int           idx;
        one = 1;
        drive();
        @(negedge clk);
        chk("busy", busy, sb.size() > 0);
        chk("op_count", op_count, m_cnt);
        while (sb.size() > 0 && sb[0].due < cyc) begin
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", rsp_valid, one << e.id);
            chk("rsp_result", rsp_result, e.res);
        end else begin
            chk("rsp_idle", rsp_valid, 0);
        end
        g = -1;
        if (!reset && !stall) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && rem[idx] > 0) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (one << g) : '0;
        chk("req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
            prod = s1[g] * s2[g];
            sb.push_back('{g, prod, cyc + 3});
            m_ptr = (g + 1) % N;
            m_cnt = m_cnt + 1;
            rem[g]--;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            sb.delete();
            m_ptr = 0;
            m_cnt = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            s1[i]  = 32'h0;
            s2[i]  = 32'h0;
        end
        drive();
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_mul_src1", mul_src1, 0);
        chk("rst_mul_src2", mul_src2, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single op from requester 0
        rem[0] = 1; s1[0] = 32'h0001_2345; s2[0] = 32'h0000_0010;
        repeat (5) tick();

        // Product wraps to the low word
        rem[2] = 1; s1[2] = 32'hFFFF_FFFF; s2[2] = 32'hFFFF_FFFF;
        repeat (5) tick();

        // Pointer now at 3: expect 3, 1, 3
        rem[1] = 1; s1[1] = 32'd7;  s2[1] = 32'd9;
        rem[3] = 2; s1[3] = 32'd11; s2[3] = 32'h8000_0001;
        repeat (7) tick();

        // Full contention
        for (int i = 0; i < N; i++) begin
            rem[i] = 2; s1[i] = 32'(i + 1); s2[i] = 32'd10;
        end
        repeat (12) tick();

        // Stall with requests pending; in-flight op still returns
        rem[0] = 1; s1[0] = 32'h1234_5678; s2[0] = 32'h0000_0003;
        rem[1] = 1; s1[1] = 32'hDEAD_BEEF; s2[1] = 32'h0000_0002;
        rem[3] = 1; s1[3] = 32'h0000_FFFF; s2[3] = 32'h0001_0001;
        tick();
        stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        repeat (6) tick();

        // Reset while two ops are in flight
        rem[0] = 1; s1[0] = 32'd5; s2[0] = 32'd6;
        rem[1] = 1; s1[1] = 32'd8; s2[1] = 32'd9;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();

        // Pointer restarted at 0
        for (int i = 0; i < N; i++) begin
            rem[i] = 1; s1[i] = 32'(3 * i + 1); s2[i] = 32'(i + 100);
        end
        repeat (8) tick();

        chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
